button_bank_debounce: RTL and testbench

BUTTON_BANK_DEBOUNCE -- requirements
Module: button_bank_debounce

---
 rtl/button_bank_debounce_pkg.sv | 45 ++++
 rtl/button_bank_debounce_channel.sv | 123 ++++++++++++
 rtl/button_bank_debounce.sv | 63 ++++++
 tb/tb_button_bank_debounce.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/button_bank_debounce_pkg.sv
// ---------------------------------------------------------------------------
// button_bank_debounce_pkg
//
// Purpose: shared definitions for the button-bank debouncer: parameter
// defaults, the stable-time derivation, the hold-counter width helper and
// the per-channel output bundle.
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package button_bank_debounce_pkg;

    // Parameter defaults used by both the top and the channel sub-module.
    localparam int DEF_CHANNELS   = 4;
    localparam int DEF_CNT_W      = 11;
    localparam int DEF_ACTIVE_LOW = 0;
    localparam int DEF_HOLD_CNT   = 0;
    localparam int DEF_REPEAT     = 0;

    // Registered outputs of one debounce channel, bundled so the top can
    // fan them out into its per-signal output vectors.
    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
        logic hold;
    } chanOut_t;

    // Number of consecutive stable cycles (M) needed before the debounced
    // level follows the synchronised input. The stability counter reaches
    // exactly M when its MSB first becomes 1.
    function automatic int stableCycles(input int cntW);
        return 1 << (cntW - 1);
    endfunction

    // Width of the long-press counter. It must hold the value HOLD_CNT so a
    // single-shot counter can park there; never narrower than one bit so
    // the register stays legal when hold detection is disabled.
    function automatic int holdCntWidth(input int holdCnt);
        if (holdCnt <= 1) begin
            return 1;
        end
        return $clog2(holdCnt + 1);
    endfunction

endpackage

// File: rtl/button_bank_debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
//
// Purpose: one button channel. Polarity correction, two-flop synchroniser,
// saturating stability counter, debounced level register, press/release
// strobes and an optional long-press (hold) strobe with single-shot or
// repeating behaviour.
//
// Ports:
//   clk_i     in   1          clock, rising edge
//   nReset_i  in   1          synchronous active-low reset
//   btn_i     in   1          raw asynchronous button level
//   chan_o    out  chanOut_t  registered level / rise / fall / hold
// ---------------------------------------------------------------------------
module debounce_channel
    import button_bank_debounce_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int ACTIVE_LOW = DEF_ACTIVE_LOW,
    parameter int HOLD_CNT   = DEF_HOLD_CNT,
    parameter int REPEAT     = DEF_REPEAT
) (
    input  logic     clk_i,
    input  logic     nReset_i,
    input  logic     btn_i,
    output chanOut_t chan_o
);

    localparam int                HOLD_W    = holdCntWidth(HOLD_CNT);
    localparam logic              HOLD_EN   = (HOLD_CNT > 0);
    localparam logic              REPEAT_EN = (REPEAT != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CNT > 0) ? HOLD_CNT - 1 : 0);
    localparam logic [HOLD_W-1:0] HOLD_TOP  = HOLD_W'((HOLD_CNT > 0) ? HOLD_CNT : 0);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic              btnPol;
    logic              sync1_q;
    logic              sync2_q;
    logic [CNT_W-1:0]  stableCnt_q;
    logic [CNT_W-1:0]  stableCnt_d;
    logic              level_q;
    logic              level_d;
    logic              rise_q;
    logic              rise_d;
    logic              fall_q;
    logic              fall_d;
    logic              hold_q;
    logic              hold_d;
    logic [HOLD_W-1:0] holdCnt_q;
    logic [HOLD_W-1:0] holdCnt_d;

    // Everything downstream works on an active-high view of the button.
    assign btnPol = (ACTIVE_LOW != 0) ? ~btn_i : btn_i;

    // Stability counter: any difference between the two synchroniser
    // stages means the input moved, so restart the count. Otherwise count
    // up until the MSB sets, then park there (MSB = "input has been stable
    // for M cycles").
    always_comb begin
        stableCnt_d = stableCnt_q;
        if (sync1_q != sync2_q) begin
            stableCnt_d = '0;
        end else if (!stableCnt_q[CNT_W-1]) begin
            stableCnt_d = stableCnt_q + CNT_ONE;
        end
    end

    // Debounced level follows the second synchroniser stage only while the
    // counter reports stability. Strobes compare the next level with the
    // current one so they appear in the same cycle as the new level.
    always_comb begin
        level_d = stableCnt_q[CNT_W-1] ? sync2_q : level_q;
        rise_d  = level_d & ~level_q;
        fall_d  = ~level_d & level_q;
    end

    // Long-press counter. It is zero in the cycle the rise strobe shows and
    // counts each cycle the level stays high, so reaching HOLD_CNT-1 means
    // the next cycle is HOLD_CNT cycles after the rise. The strobe is gated
    // with level_d so a release on that same edge wins and the hold strobe
    // never lands together with a fall strobe. Repeat mode wraps to zero to
    // re-arm; single-shot mode parks at HOLD_CNT until the button releases.
    always_comb begin
        holdCnt_d = holdCnt_q;
        hold_d    = 1'b0;
        if (!HOLD_EN || !level_q) begin
            holdCnt_d = '0;
        end else if (holdCnt_q == HOLD_LAST) begin
            hold_d    = level_d;
            holdCnt_d = REPEAT_EN ? '0 : holdCnt_q + HOLD_ONE;
        end else if (holdCnt_q != HOLD_TOP) begin
            holdCnt_d = holdCnt_q + HOLD_ONE;
        end
    end

    // All channel state. Reset clears the level without raising a fall
    // strobe because the strobes are forced to zero in the same branch.
    always_ff @(posedge clk_i) begin
        if (!nReset_i) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            stableCnt_q <= '0;
            level_q     <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            hold_q      <= 1'b0;
            holdCnt_q   <= '0;
        end else begin
            sync1_q     <= btnPol;
            sync2_q     <= sync1_q;
            stableCnt_q <= stableCnt_d;
            level_q     <= level_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            hold_q      <= hold_d;
            holdCnt_q   <= holdCnt_d;
        end
    end

    assign chan_o = {level_q, rise_q, fall_q, hold_q};

endmodule

// File: rtl/button_bank_debounce.sv
// ---------------------------------------------------------------------------
// button_bank_debounce
//
// Purpose: bank of CHANNELS independent button debouncers with press,
// release and long-press strobes plus a combined event flag.
//
// Ports:
//   clk         in   1         clock, rising edge
//   n_reset     in   1         synchronous active-low reset
//   btn_in      in   CHANNELS  raw asynchronous button levels
//   db_out      out  CHANNELS  debounced active-high levels (registered)
//   rise_pulse  out  CHANNELS  one-cycle press strobes (registered)
//   fall_pulse  out  CHANNELS  one-cycle release strobes (registered)
//   hold_pulse  out  CHANNELS  long-press strobes (registered)
//   any_event   out  1         OR of every rise, fall and hold bit
// ---------------------------------------------------------------------------
module button_bank_debounce
    import button_bank_debounce_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int ACTIVE_LOW = DEF_ACTIVE_LOW,
    parameter int HOLD_CNT   = DEF_HOLD_CNT,
    parameter int REPEAT     = DEF_REPEAT
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] db_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] hold_pulse,
    output logic                any_event
);

    chanOut_t chanOut [CHANNELS];

    // One fully independent debouncer per button; each drives only its own
    // bit of the output vectors.
    for (genvar i = 0; i < CHANNELS; i++) begin : gChan
        debounce_channel #(
            .CNT_W      (CNT_W),
            .ACTIVE_LOW (ACTIVE_LOW),
            .HOLD_CNT   (HOLD_CNT),
            .REPEAT     (REPEAT)
        ) uChan (
            .clk_i    (clk),
            .nReset_i (n_reset),
            .btn_i    (btn_in[i]),
            .chan_o   (chanOut[i])
        );

        assign db_out[i]     = chanOut[i].level;
        assign rise_pulse[i] = chanOut[i].rise;
        assign fall_pulse[i] = chanOut[i].fall;
        assign hold_pulse[i] = chanOut[i].hold;
    end

    // Combined flag for an interrupt or wake-up line; all inputs are
    // registered so this stays glitch-free apart from the OR itself.
    assign any_event = |(rise_pulse | fall_pulse | hold_pulse);

endmodule

// File: tb/tb_button_bank_debounce.sv
// ---------------------------------------------------------------------------
// tb_button_bank_debounce
//
// Purpose: directed self-checking bench for button_bank_debounce with
// CHANNELS=4, CNT_W=4 (M=8), HOLD_CNT=20. Three instances: single-shot hold
// (A), repeating hold (B) sharing A's stimulus, and an active-low bank (C).
// Edge numbers in the expectations count rising edges after the input or
// reset change; outputs are sampled 1 time unit after each edge.
// ---------------------------------------------------------------------------
module tb_button_bank_debounce;

    logic       clk = 1'b0;
    logic       rstAB;
    logic       rstC;
    logic [3:0] btnAB;
    logic [3:0] btnC;

    logic [3:0] dbA, riseA, fallA, holdA;
    logic [3:0] dbB, riseB, fallB, holdB;
    logic [3:0] dbC, riseC, fallC, holdC;
    logic       anyA, anyB, anyC;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    button_bank_debounce #(
        .CHANNELS(4), .CNT_W(4), .ACTIVE_LOW(0), .HOLD_CNT(20), .REPEAT(0)
    ) dutA (
        .clk(clk), .n_reset(rstAB), .btn_in(btnAB),
        .db_out(dbA), .rise_pulse(riseA), .fall_pulse(fallA),
        .hold_pulse(holdA), .any_event(anyA)
    );

    button_bank_debounce #(
        .CHANNELS(4), .CNT_W(4), .ACTIVE_LOW(0), .HOLD_CNT(20), .REPEAT(1)
    ) dutB (
        .clk(clk), .n_reset(rstAB), .btn_in(btnAB),
        .db_out(dbB), .rise_pulse(riseB), .fall_pulse(fallB),
        .hold_pulse(holdB), .any_event(anyB)
    );

    button_bank_debounce #(
        .CHANNELS(4), .CNT_W(4), .ACTIVE_LOW(1), .HOLD_CNT(20), .REPEAT(0)
    ) dutC (
        .clk(clk), .n_reset(rstC), .btn_in(btnC),
        .db_out(dbC), .rise_pulse(riseC), .fall_pulse(fallC),
        .hold_pulse(holdC), .any_event(anyC)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [3:0] observed,
                               input logic [3:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] btn);
        btnAB = btn;
    endtask

    // Full output check of instances A and B against hand-derived values.
    task automatic checkAB(input string tag, input logic [3:0] eDb,
                           input logic [3:0] eRise, input logic [3:0] eFall,
                           input logic [3:0] eHoldA, input logic [3:0] eHoldB);
        checkOutput({tag, " dbA"},   dbA,   eDb);
        checkOutput({tag, " riseA"}, riseA, eRise);
        checkOutput({tag, " fallA"}, fallA, eFall);
        checkOutput({tag, " holdA"}, holdA, eHoldA);
        checkOutput({tag, " anyA"},  {3'b000, anyA}, {3'b000, |(eRise | eFall | eHoldA)});
        checkOutput({tag, " dbB"},   dbB,   eDb);
        checkOutput({tag, " riseB"}, riseB, eRise);
        checkOutput({tag, " fallB"}, fallB, eFall);
        checkOutput({tag, " holdB"}, holdB, eHoldB);
        checkOutput({tag, " anyB"},  {3'b000, anyB}, {3'b000, |(eRise | eFall | eHoldB)});
    endtask

    task automatic checkC(input string tag, input logic [3:0] eDb, input logic [3:0] eRise);
        checkOutput({tag, " dbC"},   dbC,   eDb);
        checkOutput({tag, " riseC"}, riseC, eRise);
        checkOutput({tag, " fallC"}, fallC, 4'h0);
        checkOutput({tag, " holdC"}, holdC, 4'h0);
        checkOutput({tag, " anyC"},  {3'b000, anyC}, {3'b000, |eRise});
    endtask

    initial begin
        logic [3:0] eDb, eRise, eFall, eHoldA, eHoldB;

        rstAB = 1'b0;
        rstC  = 1'b0;
        btnAB = 4'hF;
        btnC  = 4'hF;

        // Reset with all buttons pressed: everything stays cleared.
        for (int e = 1; e <= 2; e++) begin
            stepEdge();
            checkAB($sformatf("rst1 e%0d", e), 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        end

        // Release: all four channels assert together at edge 11.
        rstAB = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            stepEdge();
            eDb   = (e >= 11) ? 4'hF : 4'h0;
            eRise = (e == 11) ? 4'hF : 4'h0;
            checkAB($sformatf("rel1 e%0d", e), eDb, eRise, 4'h0, 4'h0, 4'h0);
        end

        // Reset while db_out is high: cleared with no fall strobe.
        rstAB = 1'b0;
        for (int e = 1; e <= 2; e++) begin
            stepEdge();
            checkAB($sformatf("rst2 e%0d", e), 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        end

        // Release with buttons still held: debounce restarts from zero.
        rstAB = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            stepEdge();
            eDb   = (e == 11) ? 4'hF : 4'h0;
            checkAB($sformatf("rel2 e%0d", e), eDb, eDb, 4'h0, 4'h0, 4'h0);
        end

        // Let go of everything: fall strobes on all channels at edge 11.
        applyStimulus(4'h0);
        for (int e = 1; e <= 12; e++) begin
            stepEdge();
            eDb   = (e < 11) ? 4'hF : 4'h0;
            eFall = (e == 11) ? 4'hF : 4'h0;
            checkAB($sformatf("off e%0d", e), eDb, 4'h0, eFall, 4'h0, 4'h0);
        end

        // Channel 0 press held 60 edges, then released. Rise at edge 11
        // (cycle r); holds at r+20 (edge 31) and, for repeat, r+40 (edge
        // 51); release after edge 60 falls at edge 71 with no hold.
        applyStimulus(4'h1);
        for (int e = 1; e <= 75; e++) begin
            stepEdge();
            eDb    = (e >= 11 && e < 71) ? 4'h1 : 4'h0;
            eRise  = (e == 11) ? 4'h1 : 4'h0;
            eFall  = (e == 71) ? 4'h1 : 4'h0;
            eHoldA = (e == 31) ? 4'h1 : 4'h0;
            eHoldB = (e == 31 || e == 51) ? 4'h1 : 4'h0;
            checkAB($sformatf("hold e%0d", e), eDb, eRise, eFall, eHoldA, eHoldB);
            if (e == 60) begin
                applyStimulus(4'h0);
            end
        end

        // Five-cycle glitch on channel 1: nothing happens anywhere.
        applyStimulus(4'h2);
        for (int e = 1; e <= 20; e++) begin
            stepEdge();
            checkAB($sformatf("glitch e%0d", e), 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
            if (e == 5) begin
                applyStimulus(4'h0);
            end
        end

        // Channel 2 bounces (toggles after edges 0, 3, 6), then stays high:
        // one rise at edge 17, release after edge 18 falls at edge 29.
        applyStimulus(4'h4);
        for (int e = 1; e <= 30; e++) begin
            stepEdge();
            eDb   = (e >= 17 && e < 29) ? 4'h4 : 4'h0;
            eRise = (e == 17) ? 4'h4 : 4'h0;
            eFall = (e == 29) ? 4'h4 : 4'h0;
            checkAB($sformatf("bounce e%0d", e), eDb, eRise, eFall, 4'h0, 4'h0);
            if (e == 3) begin
                applyStimulus(4'h0);
            end else if (e == 6 || e == 18) begin
                applyStimulus((e == 6) ? 4'h4 : 4'h0);
            end
        end

        // Active-low bank: idle high inputs give db_out = 0.
        rstC = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            stepEdge();
            checkC($sformatf("alIdle e%0d", e), 4'h0, 4'h0);
        end

        // Press channel 3 (drive low); reset hits when the count is 5.
        btnC = 4'h7;
        for (int e = 1; e <= 7; e++) begin
            stepEdge();
            checkC($sformatf("alPress e%0d", e), 4'h0, 4'h0);
        end
        rstC = 1'b0;
        stepEdge();
        checkC("alRst", 4'h0, 4'h0);
        rstC = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            stepEdge();
            eDb   = (e >= 11) ? 4'h8 : 4'h0;
            eRise = (e == 11) ? 4'h8 : 4'h0;
            checkC($sformatf("alRel e%0d", e), eDb, eRise);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
